// File: rtl/kt1_mux_demux.sv
// rtl/kt1_mux_demux.sv - registered 4:1 mux and 1:4 demux sharing one select, each with its own enable
module kt1_mux_demux #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           A,
    input  logic                           B,
    input  logic [SEL_W-1:0]               S,
    input  logic [(2**SEL_W)*DATA_W-1:0]   Im,
    input  logic [DATA_W-1:0]              Idm,
    output logic [DATA_W-1:0]              Ym,
    output logic [(2**SEL_W)*DATA_W-1:0]   Ydm
);

    localparam int N_CH = 2**SEL_W;

    logic [DATA_W-1:0]        w_mux_next;
    logic [N_CH*DATA_W-1:0]   w_demux_next;
    logic [DATA_W-1:0]        r_ym;
    logic [N_CH*DATA_W-1:0]   r_ydm;

    // Disabled paths drive zero rather than holding their previous value.
    always_comb begin
        w_mux_next   = '0;
        w_demux_next = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (S == SEL_W'(k)) begin
                if (A) w_mux_next = Im[k*DATA_W +: DATA_W];
                if (B) w_demux_next[k*DATA_W +: DATA_W] = Idm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ym  <= '0;
            r_ydm <= '0;
        end else begin
            r_ym  <= w_mux_next;
            r_ydm <= w_demux_next;
        end
    end

    assign Ym  = r_ym;
    assign Ydm = r_ydm;

endmodule

// File: tb/tb_kt1_mux_demux.sv
// tb/tb_kt1_mux_demux.sv - table-driven scoreboard bench for kt1_mux_demux
module tb_kt1_mux_demux;

    logic       clk;
    logic       rst;
    logic       A;
    logic       B;
    logic [1:0] S;
    logic [3:0] Im;
    logic       Idm;
    logic       Ym;
    logic [3:0] Ydm;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic [1:0] s;
        logic [3:0] im;
        logic       idm;
        logic       exp_ym;
        logic [3:0] exp_ydm;
        string      name;
    } vec_t;

    typedef struct {
        logic       ym;
        logic [3:0] ydm;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[18];

    kt1_mux_demux #(.SEL_W(2), .DATA_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .S   (S),
        .Im  (Im),
        .Idm (Idm),
        .Ym  (Ym),
        .Ydm (Ydm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic a, input logic b, input logic [1:0] s,
                                input logic [3:0] im, input logic idm,
                                input logic eym, input logic [3:0] eydm, input string nm);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.im = im; v.idm = idm;
        v.exp_ym = eym; v.exp_ydm = eydm; v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic ym, input logic [3:0] ydm,
                         input logic eym, input logic [3:0] eydm);
        n_checks++;
        if (ym !== eym || ydm !== eydm) begin
            n_errors++;
            $display("FAIL %s: got Ym=%b Ydm=%b, expected Ym=%b Ydm=%b", nm, ym, ydm, eym, eydm);
        end
    endtask

    // Drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        A = v.a; B = v.b; S = v.s; Im = v.im; Idm = v.idm;
        e.ym = v.exp_ym; e.ydm = v.exp_ydm; e.name = v.name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            e = sb_q.pop_front();
            check(e.name, Ym, Ydm, e.ym, e.ydm);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 2'd0, 4'b1010, 0, 0, 4'b0000, "mux_s0");
        tbl[1]  = mk(1, 0, 2'd1, 4'b1010, 0, 1, 4'b0000, "mux_s1");
        tbl[2]  = mk(1, 0, 2'd2, 4'b1010, 1, 0, 4'b0000, "mux_s2");
        tbl[3]  = mk(1, 0, 2'd3, 4'b1010, 1, 1, 4'b0000, "mux_s3");
        tbl[4]  = mk(0, 1, 2'd0, 4'b1111, 1, 0, 4'b0001, "demux_s0");
        tbl[5]  = mk(0, 1, 2'd1, 4'b1111, 1, 0, 4'b0010, "demux_s1");
        tbl[6]  = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b0100, "demux_s2");
        tbl[7]  = mk(0, 1, 2'd3, 4'b1111, 1, 0, 4'b1000, "demux_s3");
        tbl[8]  = mk(0, 1, 2'd0, 4'b1111, 0, 0, 4'b0000, "demux_idm0_s0");
        tbl[9]  = mk(0, 1, 2'd1, 4'b1111, 0, 0, 4'b0000, "demux_idm0_s1");
        tbl[10] = mk(0, 1, 2'd2, 4'b1111, 0, 0, 4'b0000, "demux_idm0_s2");
        tbl[11] = mk(0, 1, 2'd3, 4'b1111, 0, 0, 4'b0000, "demux_idm0_s3");
        tbl[12] = mk(1, 1, 2'd2, 4'b0100, 1, 1, 4'b0100, "both_s2");
        tbl[13] = mk(1, 0, 2'd1, 4'b1101, 0, 0, 4'b0000, "mux_s1_zero");
        tbl[14] = mk(1, 1, 2'd3, 4'b1000, 1, 1, 4'b1000, "establish_s3");
        tbl[15] = mk(0, 0, 2'd3, 4'b1000, 1, 0, 4'b0000, "disable");
        tbl[16] = mk(0, 0, 2'd0, 4'b1111, 1, 0, 4'b0000, "disable_toggle1");
        tbl[17] = mk(0, 0, 2'd1, 4'b0101, 0, 0, 4'b0000, "disable_toggle2");

        rst = 1'b0; A = 1'b1; B = 1'b1; S = 2'd2; Im = 4'b1111; Idm = 1'b1;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", Ym, Ydm, 1'b0, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release_first_edge", Ym, Ydm, 1'b1, 4'b0100);

        for (int i = 0; i < 18; i++) apply(tbl[i]);

        apply(mk(1, 1, 2'd1, 4'b0010, 1, 1, 4'b0010, "pre_async"));
        #2 rst = 1'b1;
        #1 check("async_clear", Ym, Ydm, 1'b0, 4'b0000);
        @(posedge clk);
        #1 check("async_hold_over_edge", Ym, Ydm, 1'b0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1 check("async_release_no_edge", Ym, Ydm, 1'b0, 4'b0000);
        apply(mk(1, 1, 2'd1, 4'b0010, 1, 1, 4'b0010, "post_async_resume"));
        apply(mk(1, 1, 2'd0, 4'b0001, 1, 1, 4'b0001, "post_async_s0"));

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
